// File: rtl/pwm_generator.sv
// PWM generator for an LED: the duty in ticks per period tracks the brightness level.
// Brightness is latched only at the period wrap, so a level change never cuts a period short.
module pwm_generator #(
    parameter int BRIGHTNESS_WIDTH = 4,
    parameter int PRESCALE         = 1,
    parameter bit ACTIVE_LOW       = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [BRIGHTNESS_WIDTH-1:0] brightness,
    output logic                        pwm_out,
    output logic                        period_start,
    output logic [BRIGHTNESS_WIDTH-1:0] duty_q
);

    localparam int W  = BRIGHTNESS_WIDTH;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [W-1:0]  PHASE_LAST = W'((2 ** W) - 2);

    logic [PW-1:0] presc_cnt;
    logic [W-1:0]  phase;
    logic          tick;
    logic          active;

    assign tick = enable && (presc_cnt == PRESC_LAST);

    // Reset parks both counters on their last value so the first enabled edge is a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt <= PRESC_LAST;
            phase     <= PHASE_LAST;
            duty_q    <= '0;
        end else if (enable) begin
            if (tick) begin
                presc_cnt <= '0;
                if (phase == PHASE_LAST) begin
                    phase  <= '0;
                    duty_q <= brightness;
                end else begin
                    phase <= phase + 1'b1;
                end
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        active       = enable && (phase < duty_q);
        pwm_out      = active ^ ACTIVE_LOW;
        period_start = enable && (phase == '0) && (presc_cnt == '0);
    end

endmodule
